// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch timebase.
//   - default timebase parameters (stage-0 width/divisor, stage-1 width/modulus)
//   - mod_sel_e : how a mod_cnt instance obtains its modulus
//   - tb_ctrl_t : grouped control inputs {run, clr, div_load}
package stopwatch_pkg;

  localparam int unsigned CNT_W_DEF = 25;
  localparam int unsigned DIV_DEF   = 25;
  localparam int unsigned SUB_W_DEF = 7;
  localparam int unsigned SUB_DEF   = 100;

  typedef enum logic {
    MOD_RUNTIME = 1'b0,  // modulus taken from the i_mod port
    MOD_CONST   = 1'b1   // modulus fixed by the MOD parameter
  } mod_sel_e;

  typedef struct packed {
    logic run;
    logic clr;
    logic div_load;
  } tb_ctrl_t;

endpackage

// File: rtl/mod_cnt.sv
// Enable-driven modulo counter with synchronous clear and a registered wrap pulse.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   i_en           : advance the count this cycle
//   i_clr          : synchronous clear of count and pulse (beats i_en)
//   i_mod          : runtime modulus (used only when MODE == MOD_RUNTIME, must be >= 1)
//   o_wrap         : count currently sits at modulus-1 (combinational, internal use)
//   o_cnt          : registered count, 0 .. modulus-1
//   o_pulse        : registered one-cycle pulse on the edge where the count wraps
module mod_cnt
  import stopwatch_pkg::*;
#(
  parameter int unsigned W    = 8,
  parameter mod_sel_e    MODE = MOD_CONST,
  parameter int unsigned MOD  = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_en,
  input  logic         i_clr,
  input  logic [W-1:0] i_mod,
  output logic         o_wrap,
  output logic [W-1:0] o_cnt,
  output logic         o_pulse
);

  logic [W-1:0] w_last;
  logic [W-1:0] r_cnt;
  logic         r_pulse;

  generate
    if (MODE == MOD_RUNTIME) begin : g_runtime
      assign w_last = i_mod - W'(1);
    end else begin : g_const
      assign w_last = W'(MOD - 1);
      logic w_unused_mod;
      assign w_unused_mod = ^i_mod;
    end
  endgenerate

  assign o_wrap = (r_cnt == w_last);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (i_clr) begin
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else if (i_en) begin
      if (o_wrap) begin
        r_cnt   <= '0;
        r_pulse <= 1'b1;
      end else begin
        r_cnt   <= r_cnt + W'(1);
        r_pulse <= 1'b0;
      end
    end else begin
      r_pulse <= 1'b0;
    end
  end

  assign o_cnt   = r_cnt;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/stopwatch_timebase.sv
// Two-stage stopwatch timebase: stage 0 divides sub_clk by the active divisor
// (tick, out_clk, cnt); stage 1 counts ticks modulo SUB (carry, sub_cnt).
// Configuration macro: TIMEBASE_DIV_LOAD_EN enables runtime divisor loading
// through div_in/div_load; without it the divisor is the constant DIV.
// Ports:
//   rst      : asynchronous active-low reset
//   sub_clk  : clock
//   run      : 1 = count, 0 = hold (tick/carry forced low)
//   clr      : synchronous clear of both stages and out_clk
//   div_in   : runtime divisor (0 loads as 1)
//   div_load : load div_in as the active divisor
//   tick     : one-cycle pulse every divisor-th enabled cycle
//   out_clk  : toggles on every tick
//   cnt      : stage-0 count
//   carry    : one-cycle pulse when stage 1 wraps
//   sub_cnt  : stage-1 count
module stopwatch_timebase
  import stopwatch_pkg::*;
#(
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned DIV   = DIV_DEF,
  parameter int unsigned SUB_W = SUB_W_DEF,
  parameter int unsigned SUB   = SUB_DEF
) (
  input  logic             rst,
  input  logic             sub_clk,
  input  logic             run,
  input  logic             clr,
  input  logic [CNT_W-1:0] div_in,
  input  logic             div_load,
  output logic             tick,
  output logic             out_clk,
  output logic [CNT_W-1:0] cnt,
  output logic             carry,
  output logic [SUB_W-1:0] sub_cnt
);

  logic [CNT_W-1:0] w_div_q;
  logic             w_load;
  logic             w_wrap0;
  logic             w_adv;
  logic             w_unused_wrap1;
  logic             r_out_clk;

`ifdef TIMEBASE_DIV_LOAD_EN
  logic [CNT_W-1:0] r_div_q;

  always_ff @(posedge sub_clk or negedge rst) begin
    if (!rst) begin
      r_div_q <= CNT_W'(DIV);
    end else if (!clr && div_load) begin
      r_div_q <= (div_in == '0) ? CNT_W'(1) : div_in;
    end
  end

  assign w_div_q = r_div_q;
  assign w_load  = div_load & ~clr;
`else
  logic w_unused_div;
  assign w_unused_div = ^{div_in, div_load};
  assign w_div_q      = CNT_W'(DIV);
  assign w_load       = 1'b0;
`endif

  // A load restarts stage 0 but must leave stage 1 and out_clk untouched,
  // so it clears stage 0 and merely suppresses stage-1 advance.
  assign w_adv = run & ~w_load & w_wrap0;

  mod_cnt #(
    .W    (CNT_W),
    .MODE (MOD_RUNTIME),
    .MOD  (DIV)
  ) u_stage0 (
    .i_clk   (sub_clk),
    .i_rst_n (rst),
    .i_en    (run),
    .i_clr   (clr | w_load),
    .i_mod   (w_div_q),
    .o_wrap  (w_wrap0),
    .o_cnt   (cnt),
    .o_pulse (tick)
  );

  mod_cnt #(
    .W    (SUB_W),
    .MODE (MOD_CONST),
    .MOD  (SUB)
  ) u_stage1 (
    .i_clk   (sub_clk),
    .i_rst_n (rst),
    .i_en    (w_adv),
    .i_clr   (clr),
    .i_mod   ('0),
    .o_wrap  (w_unused_wrap1),
    .o_cnt   (sub_cnt),
    .o_pulse (carry)
  );

  always_ff @(posedge sub_clk or negedge rst) begin
    if (!rst) begin
      r_out_clk <= 1'b0;
    end else if (clr) begin
      r_out_clk <= 1'b0;
    end else if (w_adv) begin
      r_out_clk <= ~r_out_clk;
    end
  end

  assign out_clk = r_out_clk;

endmodule

// File: tb/tb_stopwatch_timebase.sv
// Self-checking bench for stopwatch_timebase (DIV=4, SUB=3): directed scenarios
// followed by randomized control, all compared against a behavioural model.
module tb_stopwatch_timebase;
  import stopwatch_pkg::*;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DIV   = 4;
  localparam int unsigned SUB_W = 2;
  localparam int unsigned SUB   = 3;

  localparam tb_ctrl_t C_RUN  = '{run: 1'b1, clr: 1'b0, div_load: 1'b0};
  localparam tb_ctrl_t C_STOP = '{run: 1'b0, clr: 1'b0, div_load: 1'b0};
  localparam tb_ctrl_t C_CLR  = '{run: 1'b1, clr: 1'b1, div_load: 1'b0};
  localparam tb_ctrl_t C_LOAD = '{run: 1'b1, clr: 1'b0, div_load: 1'b1};

  logic             rst;
  logic             sub_clk;
  logic             run;
  logic             clr;
  logic [CNT_W-1:0] div_in;
  logic             div_load;
  logic             tick;
  logic             out_clk;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [SUB_W-1:0] sub_cnt;

  stopwatch_timebase #(
    .CNT_W (CNT_W),
    .DIV   (DIV),
    .SUB_W (SUB_W),
    .SUB   (SUB)
  ) dut (
    .rst      (rst),
    .sub_clk  (sub_clk),
    .run      (run),
    .clr      (clr),
    .div_in   (div_in),
    .div_load (div_load),
    .tick     (tick),
    .out_clk  (out_clk),
    .cnt      (cnt),
    .carry    (carry),
    .sub_cnt  (sub_cnt)
  );

  initial sub_clk = 1'b0;
  always #5 sub_clk = ~sub_clk;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: phase within the period and ticks within the second.
  int m_cnt, m_sub, m_div, m_oc, m_tick, m_carry;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_cnt = 0; m_sub = 0; m_oc = 0; m_tick = 0; m_carry = 0; m_div = DIV;
  endtask

  task automatic model_step(input tb_ctrl_t c, input logic [CNT_W-1:0] d);
    if (c.clr) begin
      m_cnt = 0; m_sub = 0; m_oc = 0; m_tick = 0; m_carry = 0;
    end
`ifdef TIMEBASE_DIV_LOAD_EN
    else if (c.div_load) begin
      m_div = (d == 0) ? 1 : int'(d);
      m_cnt = 0; m_tick = 0; m_carry = 0;
    end
`endif
    else if (!c.run) begin
      m_tick = 0; m_carry = 0;
    end else begin
      m_cnt  = (m_cnt + 1) % m_div;
      m_tick = (m_cnt == 0);
      if (m_tick != 0) begin
        m_sub = (m_sub + 1) % SUB;
        m_oc  = 1 - m_oc;
      end
      m_carry = (m_tick != 0 && m_sub == 0);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".tick"},    32'(tick),    32'(m_tick));
    check({tag, ".out_clk"}, 32'(out_clk), 32'(m_oc));
    check({tag, ".cnt"},     32'(cnt),     32'(m_cnt));
    check({tag, ".carry"},   32'(carry),   32'(m_carry));
    check({tag, ".sub_cnt"}, 32'(sub_cnt), 32'(m_sub));
  endtask

  // Called at posedge+1; drives, waits for the edge, models, checks at +1.
  task automatic step(input tb_ctrl_t c, input logic [CNT_W-1:0] d, input string tag);
    run = c.run; clr = c.clr; div_load = c.div_load; div_in = d;
    @(posedge sub_clk);
    model_step(c, d);
    #1;
    check_all(tag);
  endtask

  // Called at posedge+1: asserts reset between edges and checks its immediate effect.
  task automatic async_reset(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    check_all(tag);
    check({tag, ".tick0"}, 32'(tick), 32'd0);
    #2;
    rst = 1'b1;
  endtask

  initial begin
    int ticks;
    int carries;
    int found;
    tb_ctrl_t c;

    run = 1'b0; clr = 1'b0; div_load = 1'b0; div_in = '0;
    rst = 1'b1;
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_all("reset");
    @(posedge sub_clk);
    #1 rst = 1'b1;

    // Free run: tick every 4th cycle, carry every 12th.
    for (int i = 1; i <= 24; i++) begin
      step(C_RUN, '0, "s1");
      check($sformatf("s1.tick@%0d", i), 32'(tick), 32'((i % 4) == 0));
      check($sformatf("s1.carry@%0d", i), 32'(carry), 32'((i % 12) == 0));
      if (i % 4 == 0)
        check($sformatf("s1.oclk@%0d", i), 32'(out_clk), 32'((i / 4) % 2));
    end

    // Stop at cnt=2, then resume: tick after exactly two enabled cycles.
    step(C_RUN, '0, "s2");
    step(C_RUN, '0, "s2");
    for (int i = 0; i < 5; i++) begin
      step(C_STOP, '0, "s2stop");
      check("s2.hold_cnt", 32'(cnt), 32'd2);
      check("s2.no_tick", 32'(tick), 32'd0);
    end
    step(C_RUN, '0, "s2");
    check("s2.resume1", 32'(tick), 32'd0);
    step(C_RUN, '0, "s2");
    check("s2.resume2", 32'(tick), 32'd1);

    // Clear on cnt=3 suppresses the tick.
    for (int i = 0; i < 3; i++) step(C_RUN, '0, "s3");
    check("s3.at3", 32'(cnt), 32'd3);
    step(C_CLR, '0, "s3clr");
    check("s3.tick", 32'(tick), 32'd0);
    check("s3.cnt", 32'(cnt), 32'd0);
    check("s3.sub", 32'(sub_cnt), 32'd0);
    check("s3.oclk", 32'(out_clk), 32'd0);

    // Runtime divisor load mid-period.
    step(C_RUN, '0, "s4");
    step(C_LOAD, CNT_W'(2), "s4load");
`ifdef TIMEBASE_DIV_LOAD_EN
    check("s4.cnt_after_load", 32'(cnt), 32'd0);
`endif
    ticks = 0;
    for (int i = 0; i < 4; i++) begin
      step(C_RUN, '0, "s4");
      ticks += int'(tick);
    end
`ifdef TIMEBASE_DIV_LOAD_EN
    check("s4.ticks_div2", 32'(ticks), 32'd2);
`else
    check("s4.ticks_div4", 32'(ticks), 32'd1);
`endif
    step(C_LOAD, '0, "s4load0");
    ticks = 0;
    for (int i = 0; i < 4; i++) begin
      step(C_RUN, '0, "s4");
      ticks += int'(tick);
    end
`ifdef TIMEBASE_DIV_LOAD_EN
    check("s4.ticks_div1", 32'(ticks), 32'd4);
`else
    check("s4.ticks_div4b", 32'(ticks), 32'd1);
`endif
    step(C_LOAD, CNT_W'(DIV), "s4restore");

    // Reset mid-count at sub_cnt=2, cnt=3.
    found = 0;
    for (int i = 0; i < 200 && found == 0; i++) begin
      step(C_RUN, '0, "s6");
      if (m_sub == 2 && m_cnt == 3) found = 1;
    end
    check("s6.reached", 32'(found), 32'd1);
    async_reset("s6rst");
    check("s6.cnt0", 32'(cnt), 32'd0);
    check("s6.sub0", 32'(sub_cnt), 32'd0);
    for (int i = 1; i <= 4; i++) begin
      step(C_RUN, '0, "s6");
      check($sformatf("s6.tick@%0d", i), 32'(tick), 32'(i == 4));
    end

    // Randomized control against the model.
    carries = 0;
    for (int i = 0; i < 3000; i++) begin
      c.run      = ($urandom_range(0, 9) < 8);
      c.clr      = ($urandom_range(0, 49) == 0);
      c.div_load = ($urandom_range(0, 29) == 0);
      step(c, CNT_W'($urandom_range(0, 6)), "rnd");
      carries += int'(carry);
      if ($urandom_range(0, 499) == 0) async_reset("rndrst");
    end
    check("rnd.saw_carry", 32'(carries > 0), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
